fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_pc_counter.sv | 31 +++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
// Imported by fetch_unit and pc_counter.
package fetch_unit_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] FETCH_OPCODE = 8'h00;
    localparam logic [DATA_W-1:0] HALT_OPCODE  = 8'hFF;
    localparam logic [2:0]        DEST_HALT    = 3'd7;

    // The destination field in IR[2:0] selects halt when it equals DEST_HALT.
    function automatic logic is_halt(input logic [DATA_W-1:0] instr);
        return (instr[2:0] == DEST_HALT);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: synchronous reset, parallel load with priority over
// increment, 8-bit modulo arithmetic.
module pc_counter
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] pc_r;

    // Counter register: reset, then load, then increment, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= 8'h00;
        end else if (load) begin
            pc_r <= d;
        end else if (inc) begin
            pc_r <= pc_r + 8'h01;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign q = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Fetch/execute sequencer: holds IR, the zero/carry flags and the
// FETCH/EXEC/HALT state, and drives the PC counter.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] bus,
    input  logic              loadBarIR,
    input  logic              loadBarA,
    input  logic              assertBarRom,
    input  logic              doJump,
    input  logic [DATA_W-1:0] aluResult,
    input  logic              aluCout,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] pc,
    output logic              aIsZero,
    output logic              flagCarry,
    output logic              halted
);

    state_t            state_r;
    state_t            next_state_s;
    logic [DATA_W-1:0] ir_r;
    logic              zero_r;
    logic              carry_r;

    logic              ir_load_s;
    logic              flag_load_s;
    logic              pc_load_s;
    logic              pc_inc_s;
    logic [DATA_W-1:0] ir_s;

    // Next-state and register-enable decode for the sequencer.
    always_comb begin
        next_state_s = state_r;
        ir_load_s    = 1'b0;
        flag_load_s  = 1'b0;
        pc_load_s    = 1'b0;
        pc_inc_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (run && !loadBarIR) begin
                    ir_load_s    = 1'b1;
                    pc_inc_s     = 1'b1;
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (is_halt(ir_r)) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_FETCH;
                    flag_load_s  = !loadBarA;
                    // A jump whose target comes from the ROM immediate must not also step past it.
                    if (doJump) begin
                        pc_load_s = 1'b1;
                    end else if (!assertBarRom) begin
                        pc_inc_s = 1'b1;
                    end else begin
                        pc_inc_s = 1'b0;
                    end
                end
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_FETCH;
            end
        endcase
    end

    // Sequencer state, instruction register and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
            ir_r    <= 8'h00;
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (ir_load_s) begin
                ir_r <= bus;
            end else begin
                ir_r <= ir_r;
            end
            if (flag_load_s) begin
                zero_r  <= (aluResult == 8'h00);
                carry_r <= aluCout;
            end else begin
                zero_r  <= zero_r;
                carry_r <= carry_r;
            end
        end
    end

    pc_counter u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load_s),
        .inc   (pc_inc_s),
        .d     (bus),
        .q     (pc)
    );

    // Instruction seen by control decode depends only on the registered state.
    always_comb begin
        ir_s = FETCH_OPCODE;
        case (state_r)
            ST_FETCH: ir_s = FETCH_OPCODE;
            ST_EXEC:  ir_s = ir_r;
            ST_HALT:  ir_s = HALT_OPCODE;
            default:  ir_s = FETCH_OPCODE;
        endcase
    end

    assign ir        = ir_s;
    assign aIsZero   = zero_r;
    assign flagCarry = carry_r;
    assign halted    = (state_r == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: one table row per clock,
// expected outputs are hand-computed values after that edge.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] bus;
    logic       loadBarIR;
    logic       loadBarA;
    logic       assertBarRom;
    logic       doJump;
    logic [7:0] aluResult;
    logic       aluCout;
    logic [7:0] ir;
    logic [7:0] pc;
    logic       aIsZero;
    logic       flagCarry;
    logic       halted;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       run;
        logic [7:0] bus;
        logic       lb_ir;
        logic       lb_a;
        logic       ab_rom;
        logic       jmp;
        logic [7:0] alu;
        logic       cout;
        logic [7:0] e_ir;
        logic [7:0] e_pc;
        logic       e_z;
        logic       e_c;
        logic       e_h;
    } vec_t;

    vec_t vecs[$];

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .bus          (bus),
        .loadBarIR    (loadBarIR),
        .loadBarA     (loadBarA),
        .assertBarRom (assertBarRom),
        .doJump       (doJump),
        .aluResult    (aluResult),
        .aluCout      (aluCout),
        .ir           (ir),
        .pc           (pc),
        .aIsZero      (aIsZero),
        .flagCarry    (flagCarry),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic rn, input logic [7:0] b,
                       input logic lbi, input logic lba, input logic abr,
                       input logic jp, input logic [7:0] al, input logic co,
                       input logic [7:0] eir, input logic [7:0] epc,
                       input logic ez, input logic ec, input logic eh);
        vec_t v;
        v.rst = rst; v.run = rn; v.bus = b; v.lb_ir = lbi; v.lb_a = lba;
        v.ab_rom = abr; v.jmp = jp; v.alu = al; v.cout = co;
        v.e_ir = eir; v.e_pc = epc; v.e_z = ez; v.e_c = ec; v.e_h = eh;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; run = v.run; bus = v.bus; loadBarIR = v.lb_ir;
        loadBarA = v.lb_a; assertBarRom = v.ab_rom; doJump = v.jmp;
        aluResult = v.alu; aluCout = v.cout;
    endtask

    task automatic check8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check1(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check8("ir", idx, ir, v.e_ir);
        check8("pc", idx, pc, v.e_pc);
        check1("aIsZero", idx, aIsZero, v.e_z);
        check1("flagCarry", idx, flagCarry, v.e_c);
        check1("halted", idx, halted, v.e_h);
    endtask

    initial begin
        vec_t v;
        //   rst run bus   lbI lbA abR jmp alu   co   ir     pc     z    c    h
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // reset
        add(1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12, 8'h01, 1'b0, 1'b0, 1'b0); // fetch 0x12
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0); // exec, load A = 0, carry
        add(1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0A, 8'h02, 1'b1, 1'b1, 1'b0); // fetch 0x0A
        add(1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 8'h00, 8'h40, 1'b1, 1'b1, 1'b0); // jump from ROM, flags hold
        add(1'b0, 1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h21, 8'h41, 1'b1, 1'b1, 1'b0); // fetch 0x21
        add(1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0); // immediate consumed, A=5
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0); // run=0 hold
        add(1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0A, 8'h43, 1'b0, 1'b0, 1'b0); // fetch
        add(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0); // jump to 0xFF
        add(1'b0, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h0A, 8'h00, 1'b0, 1'b0, 1'b0); // wrap, no flag change in FETCH
        add(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); // pc hold, carry only
        add(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h33, 8'h01, 1'b0, 1'b1, 1'b0); // fetch
        add(1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // reset mid-EXEC
        add(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0); // fetch halt
        add(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1); // halt: no pc/flag update

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_all(i, vecs[i]);
        end

        // Stay halted for 10 cycles with run toggling and hostile controls.
        for (int i = 0; i < 10; i++) begin
            v = vecs[vecs.size()-1];
            v.run = i[0];
            v.bus = 8'hA0 + 8'(i);
            v.lb_ir = 1'b0;
            drive(v);
            @(posedge clk);
            #1;
            check8("halt_ir", i, ir, 8'hFF);
            check8("halt_pc", i, pc, 8'h01);
            check1("halt_flag", i, halted, 1'b1);
            check1("halt_z", i, aIsZero, 1'b0);
        end

        // Reset releases HALT; the next fetch reads ROM address 0x00.
        reset = 1'b1; run = 1'b1;
        @(posedge clk);
        #1;
        check8("rst_pc", 0, pc, 8'h00);
        check8("rst_ir", 0, ir, 8'h00);
        check1("rst_halted", 0, halted, 1'b0);
        reset = 1'b0; bus = 8'h3C; loadBarIR = 1'b0;
        check8("addr0", 0, pc, 8'h00);
        @(posedge clk);
        #1;
        check8("post_rst_ir", 0, ir, 8'h3C);
        check8("post_rst_pc", 0, pc, 8'h01);
        // Exactly one EXEC cycle before returning to FETCH.
        loadBarIR = 1'b1; assertBarRom = 1'b1; doJump = 1'b0; loadBarA = 1'b1;
        @(posedge clk);
        #1;
        check8("latency_ir", 0, ir, 8'h00);
        check8("latency_pc", 0, pc, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
